// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform generator phase path.
// Holds the default widths, the phase FSM state encoding and the sweep step width.
package wavegen_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int SWEEP_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // The state follows enable and the pending-slot flag that will hold after this edge.
  function automatic state_e next_state(input logic enable, input logic pend_full);
    if (!enable) begin
      return IDLE;
    end else if (pend_full) begin
      return PEND;
    end else begin
      return RUN;
    end
  endfunction

endpackage

// File: rtl/freq_sweep_unit.sv
// Frequency-word update logic for the chirp feature (used only with WAVEGEN_SWEEP_EN).
// A pending-word apply wins over a sweep step; an out-of-range step falls back to the base word.
module freq_sweep_unit
  import wavegen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               apply,
  input  logic               step_en,
  input  logic [ACC_W-1:0]   pend_fw,
  input  logic [ACC_W-1:0]   active_fw,
  input  logic [ACC_W-1:0]   base_fw,
  input  logic [SWEEP_W-1:0] sweep_step,
  input  logic [ACC_W-1:0]   sweep_stop,
  output logic [ACC_W-1:0]   active_fw_next,
  output logic [ACC_W-1:0]   base_fw_next
);

  logic [ACC_W:0] step_sum;

  always_comb begin
    step_sum       = {1'b0, active_fw} + {{(ACC_W + 1 - SWEEP_W){1'b0}}, sweep_step};
    active_fw_next = active_fw;
    base_fw_next   = base_fw;
    if (apply) begin
      active_fw_next = pend_fw;
      base_fw_next   = pend_fw;
    end else if (step_en) begin
      // Either a carry out of ACC_W or passing the stop word restarts the chirp.
      if (step_sum[ACC_W] || (step_sum[ACC_W-1:0] > sweep_stop)) begin
        active_fw_next = base_fw;
      end else begin
        active_fw_next = step_sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/phase_address_generator.sv
// DDS phase accumulator producing the table address and a wrap strobe; new frequency words
// take effect only at a phase wrap. Optional chirp sweep is built when WAVEGEN_SWEEP_EN is defined.
module phase_address_generator
  import wavegen_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic               freq_valid,
  output logic               freq_ready,
  input  logic [ADDR_W-1:0]  phase_off,
  output logic [ADDR_W-1:0]  address,
  output logic               wrap
`ifdef WAVEGEN_SWEEP_EN
  ,
  input  logic               sweep_on,
  input  logic [SWEEP_W-1:0] sweep_step,
  input  logic [ACC_W-1:0]   sweep_stop
`endif
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  active_fw_q, active_fw_d;
  logic [ACC_W-1:0]  pend_fw_q, pend_fw_d;
  logic              pend_full_q, pend_full_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              wrap_q, wrap_d;

  logic              running;
  logic              carry;
  logic [ACC_W-1:0]  acc_sum;
  logic              take;
  logic              apply;

`ifdef WAVEGEN_SWEEP_EN
  logic [ACC_W-1:0]  base_fw_q, base_fw_d;
  logic [ACC_W-1:0]  sweep_active_fw;
  logic              step_en;

  freq_sweep_unit #(
    .ACC_W(ACC_W)
  ) u_sweep (
    .apply         (apply),
    .step_en       (step_en),
    .pend_fw       (pend_fw_q),
    .active_fw     (active_fw_q),
    .base_fw       (base_fw_q),
    .sweep_step    (sweep_step),
    .sweep_stop    (sweep_stop),
    .active_fw_next(sweep_active_fw),
    .base_fw_next  (base_fw_d)
  );
`endif

  always_comb begin
    // The edge that leaves IDLE still holds phase at zero; accumulation starts one edge later.
    running        = enable && (state_q != IDLE);
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, active_fw_q};
    take           = freq_valid && !pend_full_q;
    // A zero increment never wraps, and IDLE has no phase to protect, so apply at once there.
    apply          = pend_full_q &&
                     ((running && carry) || (active_fw_q == '0) || (state_q == IDLE));

    acc_d       = running ? acc_sum : '0;
    wrap_d      = running && carry;
    address_d   = running ? (acc_q[ACC_W-1 -: ADDR_W] + phase_off) : '0;
    pend_fw_d   = take ? freq_word : pend_fw_q;
    pend_full_d = take ? 1'b1 : (apply ? 1'b0 : pend_full_q);
    state_d     = next_state(enable, pend_full_d);

`ifdef WAVEGEN_SWEEP_EN
    step_en     = running && carry && sweep_on && !pend_full_q;
    active_fw_d = sweep_active_fw;
`else
    active_fw_d = apply ? pend_fw_q : active_fw_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      active_fw_q <= '0;
      pend_fw_q   <= '0;
      pend_full_q <= 1'b0;
      address_q   <= '0;
      wrap_q      <= 1'b0;
`ifdef WAVEGEN_SWEEP_EN
      base_fw_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      active_fw_q <= active_fw_d;
      pend_fw_q   <= pend_fw_d;
      pend_full_q <= pend_full_d;
      address_q   <= address_d;
      wrap_q      <= wrap_d;
`ifdef WAVEGEN_SWEEP_EN
      base_fw_q   <= base_fw_d;
`endif
    end
  end

  assign freq_ready = ~pend_full_q;
  assign address    = address_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_phase_address_generator.sv
// Scoreboard bench for phase_address_generator: directed stimulus at fixed cycles pushes
// hand-computed expectations; a negedge monitor pops and compares them cycle by cycle.
module tb_phase_address_generator;
  import wavegen_pkg::*;

  localparam logic [2:0] M_A = 3'b001;
  localparam logic [2:0] M_W = 3'b010;
  localparam logic [2:0] M_R = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] freq_word;
  logic        freq_valid;
  logic        freq_ready;
  logic [8:0]  phase_off;
  logic [8:0]  address;
  logic        wrap;
`ifdef WAVEGEN_SWEEP_EN
  logic        sweep_on   = 1'b0;
  logic [15:0] sweep_step = 16'h0;
  logic [31:0] sweep_stop = 32'h0;
`endif

  typedef struct {
    int         cyc;
    string      name;
    logic [8:0] addr;
    logic       wrp;
    logic       rdy;
    logic [2:0] mask;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  phase_address_generator #(
    .ACC_W (32),
    .ADDR_W(9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .freq_word (freq_word),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .phase_off (phase_off),
    .address   (address),
    .wrap      (wrap)
`ifdef WAVEGEN_SWEEP_EN
    ,
    .sweep_on  (sweep_on),
    .sweep_step(sweep_step),
    .sweep_stop(sweep_stop)
`endif
  );

  // Free-running clock and an edge counter that timestamps every expectation.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one scoreboard entry against what the DUT shows this cycle.
  task checkOutput(input exp_t e);
    if (e.mask[0]) begin
      checks++;
      if (address !== e.addr) begin
        errors++;
        $display("[TB] FAIL %s cyc=%0d address got %0h want %0h", e.name, cyc, address, e.addr);
      end
    end
    if (e.mask[1]) begin
      checks++;
      if (wrap !== e.wrp) begin
        errors++;
        $display("[TB] FAIL %s cyc=%0d wrap got %b want %b", e.name, cyc, wrap, e.wrp);
      end
    end
    if (e.mask[2]) begin
      checks++;
      if (freq_ready !== e.rdy) begin
        errors++;
        $display("[TB] FAIL %s cyc=%0d freq_ready got %b want %b", e.name, cyc, freq_ready, e.rdy);
      end
    end
  endtask

  // Monitor: on every falling edge, pop all entries stamped with the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale entry for cyc %0d seen at %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        checkOutput(mon_e);
      end
    end
  end

  // Push an expectation for the registered outputs after posedge number c.
  task automatic expectAt(input int c, input string n, input logic [8:0] a,
                          input logic w, input logic r, input logic [2:0] m);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.addr = a;
    e.wrp  = w;
    e.rdy  = r;
    e.mask = m;
    sb_q.push_back(e);
  endtask

  // Drive all inputs 2 time units after posedge number c; they are sampled at edge c+1.
  task automatic applyStimulus(input int c, input logic r, input logic en, input logic v,
                               input logic [31:0] fw, input logic [8:0] off);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("[TB] FAIL schedule wanted cyc %0d now %0d", c, cyc);
    end
    rst_n      = r;
    enable     = en;
    freq_valid = v;
    freq_word  = fw;
    phase_off  = off;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence; every expected value below is worked out by hand from the cycle numbers.
  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    freq_valid = 1'b0;
    freq_word  = 32'h0;
    phase_off  = 9'h0;

    // Reset held for edges 1..3 with enable high.
    for (int i = 1; i <= 3; i++) expectAt(i, "reset", 9'h0, 1'b0, 1'b1, M_A | M_W | M_R);

    // Load 0x0080_0000 while idle: captured at edge 4, applied in IDLE at edge 5.
    applyStimulus(3, 1'b1, 1'b0, 1'b1, 32'h0080_0000, 9'h0);
    expectAt(4, "idle_load_busy", 9'h0, 1'b0, 1'b0, M_A | M_R);
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 32'h0, 9'h0);
    expectAt(5, "idle_load_applied", 9'h0, 1'b0, 1'b1, M_A | M_R);

    // Run: edge 6 leaves IDLE, acc starts at edge 7, address = n-7.
    applyStimulus(5, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    expectAt(6, "run_start", 9'h0, 1'b0, 1'b1, M_A | M_W);
    expectAt(7, "run_step0", 9'h0, 1'b0, 1'b1, M_A | M_W);
    expectAt(8, "run_step1", 9'h1, 1'b0, 1'b1, M_A | M_W);
    expectAt(9, "run_step2", 9'h2, 1'b0, 1'b1, M_A | M_W);
    expectAt(10, "run_step3", 9'h3, 1'b0, 1'b1, M_A | M_W);
    expectAt(517, "pre_wrap", 9'd510, 1'b0, 1'b1, M_A | M_W);
    expectAt(518, "wrap1", 9'd511, 1'b1, 1'b1, M_A | M_W);
    expectAt(519, "post_wrap", 9'd0, 1'b0, 1'b1, M_A | M_W);
    expectAt(520, "post_wrap1", 9'd1, 1'b0, 1'b1, M_A | M_W);

    // Mid-period load of 0x0100_0000 waits for the wrap at edge 1030.
    applyStimulus(700, 1'b1, 1'b1, 1'b1, 32'h0100_0000, 9'h0);
    expectAt(701, "upd_busy", 9'h0, 1'b0, 1'b0, M_R);
    applyStimulus(701, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    expectAt(1029, "upd_still_busy", 9'd510, 1'b0, 1'b0, M_A | M_W | M_R);
    expectAt(1030, "upd_wrap", 9'd511, 1'b1, 1'b1, M_A | M_W | M_R);
    expectAt(1031, "upd_step0", 9'd0, 1'b0, 1'b1, M_A | M_W);
    expectAt(1032, "upd_step2", 9'd2, 1'b0, 1'b1, M_A);
    expectAt(1033, "upd_step4", 9'd4, 1'b0, 1'b1, M_A);
    expectAt(1285, "fast_pre_wrap", 9'd508, 1'b0, 1'b1, M_A | M_W);
    expectAt(1286, "fast_wrap", 9'd510, 1'b1, 1'b1, M_A | M_W);
    expectAt(1287, "fast_post_wrap", 9'd0, 1'b0, 1'b1, M_A | M_W);
    expectAt(1541, "fast_gap", 9'd508, 1'b0, 1'b1, M_W);
    expectAt(1542, "fast_wrap2", 9'd510, 1'b1, 1'b1, M_W);

    // Zero increment loaded, applied at wrap 1798; then phase_off=5 freezes the address at 5.
    applyStimulus(1550, 1'b1, 1'b1, 1'b1, 32'h0, 9'h0);
    expectAt(1551, "zero_busy", 9'h0, 1'b0, 1'b0, M_R);
    applyStimulus(1551, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    expectAt(1797, "zero_wait", 9'h0, 1'b0, 1'b0, M_W | M_R);
    expectAt(1798, "zero_applied", 9'h0, 1'b1, 1'b1, M_W | M_R);
    applyStimulus(1800, 1'b1, 1'b1, 1'b0, 32'h0, 9'h5);
    expectAt(1801, "zero_off", 9'h5, 1'b0, 1'b1, M_A | M_W);
    expectAt(1805, "zero_hold", 9'h5, 1'b0, 1'b1, M_A | M_W);
    expectAt(1809, "zero_hold2", 9'h5, 1'b0, 1'b1, M_A | M_W | M_R);

    // With active word zero a new load applies on the very next edge.
    applyStimulus(1810, 1'b1, 1'b1, 1'b1, 32'h0080_0000, 9'h5);
    expectAt(1811, "zero_reload_busy", 9'h5, 1'b0, 1'b0, M_A | M_R);
    applyStimulus(1811, 1'b1, 1'b1, 1'b0, 32'h0, 9'h5);
    expectAt(1812, "zero_reload_free", 9'h5, 1'b0, 1'b1, M_A | M_R);
    expectAt(1813, "zero_reload_s0", 9'h5, 1'b0, 1'b1, M_A);
    expectAt(1814, "zero_reload_s1", 9'h6, 1'b0, 1'b1, M_A);
    expectAt(1815, "zero_reload_s2", 9'h7, 1'b0, 1'b1, M_A);

    // Enable toggle restarts phase; offset 0x1F0 exercises address modulo.
    applyStimulus(1820, 1'b1, 1'b0, 1'b0, 32'h0, 9'h5);
    expectAt(1821, "idle_clear", 9'h0, 1'b0, 1'b1, M_A | M_W);
    applyStimulus(1822, 1'b1, 1'b1, 1'b0, 32'h0, 9'h1F0);
    expectAt(1823, "restart", 9'h0, 1'b0, 1'b1, M_A);
    expectAt(1824, "off_1f0", 9'h1F0, 1'b0, 1'b1, M_A);
    expectAt(1825, "off_1f1", 9'h1F1, 1'b0, 1'b1, M_A);
    expectAt(1839, "off_1ff", 9'h1FF, 1'b0, 1'b1, M_A);
    expectAt(1840, "off_000", 9'h000, 1'b0, 1'b1, M_A | M_W);
    expectAt(1841, "off_001", 9'h001, 1'b0, 1'b1, M_A);

    // Pending word with enable falling: applied in IDLE on the following edge.
    applyStimulus(1850, 1'b1, 1'b1, 1'b1, 32'h0100_0000, 9'h1F0);
    expectAt(1851, "pend_busy", 9'h0, 1'b0, 1'b0, M_R);
    applyStimulus(1851, 1'b1, 1'b1, 1'b0, 32'h0, 9'h1F0);
    applyStimulus(1855, 1'b1, 1'b0, 1'b0, 32'h0, 9'h1F0);
    expectAt(1856, "pend_fall", 9'h0, 1'b0, 1'b0, M_A | M_R);
    expectAt(1857, "pend_idle_apply", 9'h0, 1'b0, 1'b1, M_A | M_R);
    applyStimulus(1860, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    expectAt(1862, "pend_run0", 9'h0, 1'b0, 1'b1, M_A);
    expectAt(1863, "pend_run2", 9'h2, 1'b0, 1'b1, M_A);
    expectAt(1864, "pend_run4", 9'h4, 1'b0, 1'b1, M_A);

    // Handshake on the carry edge (2117): captured now, applied only at the next wrap (2373).
    applyStimulus(2116, 1'b1, 1'b1, 1'b1, 32'h0080_0000, 9'h0);
    expectAt(2116, "hs_wrap_pre", 9'd508, 1'b0, 1'b1, M_A | M_W | M_R);
    expectAt(2117, "hs_wrap_edge", 9'd510, 1'b1, 1'b0, M_A | M_W | M_R);
    applyStimulus(2117, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    expectAt(2118, "hs_wrap_after", 9'd0, 1'b0, 1'b0, M_A | M_W | M_R);
    expectAt(2372, "hs_wait", 9'd508, 1'b0, 1'b0, M_A | M_W | M_R);
    expectAt(2373, "hs_applied", 9'd510, 1'b1, 1'b1, M_A | M_W | M_R);
    expectAt(2375, "hs_slow1", 9'd1, 1'b0, 1'b1, M_A);
    expectAt(2376, "hs_slow2", 9'd2, 1'b0, 1'b1, M_A);

`ifdef WAVEGEN_SWEEP_EN
    // Chirp from base 0x0080_0000 in 0x8000 steps, reloading once past 0x0082_0000.
    applyStimulus(2377, 1'b1, 1'b1, 1'b0, 32'h0, 9'h0);
    sweep_step = 16'h8000;
    sweep_stop = 32'h0082_0000;
    sweep_on   = 1'b1;
    begin
      logic [31:0] sweep_exp [5];
      sweep_exp[0] = 32'h0080_8000;
      sweep_exp[1] = 32'h0081_0000;
      sweep_exp[2] = 32'h0081_8000;
      sweep_exp[3] = 32'h0082_0000;
      sweep_exp[4] = 32'h0080_0000;
      for (int i = 0; i < 5; i++) begin
        int budget;
        budget = 0;
        do begin
          @(negedge clk);
          budget++;
        end while (!wrap && budget < 600);
        checks++;
        if (!wrap || dut.active_fw_q !== sweep_exp[i]) begin
          errors++;
          $display("[TB] FAIL sweep_wrap%0d wrap=%b active_fw got %0h want %0h",
                   i, wrap, dut.active_fw_q, sweep_exp[i]);
        end
      end
    end
    sweep_on = 1'b0;
`endif

    // Let the monitor drain what is left, bounded.
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_address_generator.md
Name: phase_address_generator

Overview:
- DDS phase accumulator directly upstream of the waveform selection stage.
- Produces the 9-bit table/phase address consumed by the sine ROM and by the triangle/square/PWM derivation.
- Accepts frequency-word updates through a valid/ready handshake and applies them only at a phase wrap, so output periods stay glitch-free.
- Provides a wrap strobe for downstream sync.

Parameters:
- ACC_W, 32: accumulator width in bits.
- ADDR_W, 9: output address width in bits; top ADDR_W bits of the accumulator.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- enable  in  1  1 = run, 0 = idle with phase cleared.
- freq_word  in  ACC_W  new phase increment.
- freq_valid  in  1  freq_word offered.
- freq_ready  out  1  pending slot free; transfer when freq_valid and freq_ready are both 1.
- phase_off  in  ADDR_W  phase offset added to the address.
- address  out  ADDR_W  registered phase address.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - acc, active_fw, pend_fw, address and wrap are all 0.
  - pend_full=0, freq_ready=1, state=IDLE.
- State machine:
  - IDLE: enable=0. acc is held at 0, address at 0 and wrap at 0.
  - RUN: enable=1 and pend_full=0.
  - PEND: enable=1 and pend_full=1.
  - Transitions:
    - IDLE to RUN when enable=1.
    - RUN to PEND on a handshake.
    - PEND to RUN when the pending word is applied.
    - Any state to IDLE when enable=0.
- Accumulation in RUN/PEND: {carry, acc_next} = acc + active_fw, ACC_W-bit modulo; wrap <= carry.
- Address: address <= acc[ACC_W-1 -: ADDR_W] + phase_off, modulo 2^ADDR_W.
  - Latency is one cycle after acc.
  - phase_off takes effect on the next edge, with no wrap gating.
- Handshake:
  - freq_ready = ~pend_full.
  - A transfer loads pend_fw and sets pend_full.
- Applying the pending word: active_fw <= pend_fw and pend_full is cleared, in any of these cases:
  - on the edge where carry=1;
  - on the next edge if active_fw==0 (no wrap would otherwise ever occur);
  - on the next edge if in IDLE.
- Simultaneous events:
  - Handshake on the same edge as a carry, with the slot empty: the word is captured and applied at the following wrap, not this one.
  - enable falls while PEND: the pending word is applied in IDLE on the next edge.
- freq_word=0 is legal: address freezes at the offset-adjusted phase and wrap stays 0.
- enable toggled 1 to 0 to 1: phase restarts from 0; active_fw is retained.

Optional Feature:
- Macro: WAVEGEN_SWEEP_EN.
- Defined:
  - Adds ports sweep_on (in 1), sweep_step (in 16) and sweep_stop (in ACC_W).
  - Internal base_fw register holds the last applied loaded word.
  - On each carry with sweep_on=1 and pend_full=0: active_fw <= active_fw + sweep_step.
  - If that sum exceeds sweep_stop or overflows ACC_W, active_fw <= base_fw instead (sawtooth chirp).
  - A pending-word apply takes priority over a sweep step and also updates base_fw.
- Undefined: none of these ports or registers exist; active_fw changes only via the handshake.

Decomposition:
- Shared package wavegen_pkg holds:
  - ACC_W_DEF=32 and ADDR_W_DEF=9;
  - state enum {IDLE, RUN, PEND}, 2 bits;
  - the sweep step width constant SWEEP_W=16.
- Core datapath is flat.
- One sub-module, freq_sweep_unit (active_fw/base_fw update logic), is instantiated only under WAVEGEN_SWEEP_EN.

Test Plan:
- Reset: rst_n=0 for 3 cycles with enable=1 -> address=0, wrap=0, freq_ready=1.
- Basic run: load freq_word=0x0080_0000, enable=1, phase_off=0 -> address steps by 1 per clk; wrap pulses once every 512 cycles, aligned with the 511 to 0 transition.
- Update at wrap: running with 0x0080_0000, load 0x0100_0000 mid-period -> freq_ready=0 until the next wrap; then address steps by 2 and wrap repeats every 256 cycles.
- Zero increment: active_fw=0, phase_off=0x05 -> address=5 constant, no wrap; a new load applies on the next edge and freq_ready returns to 1.
- Offset and modulo: freq 0x0080_0000 with phase_off=0x1F0 -> address sequence 0x1F0, 0x1F1 ... 0x1FF, 0x000.
- Sweep (WAVEGEN_SWEEP_EN defined): base 0x0080_0000, sweep_step=0x8000, sweep_stop=0x0082_0000 -> active_fw increments by 0x8000 on each of the first 4 wraps and reloads 0x0080_0000 on the 5th.
